// File: rtl/elev_pkg.sv
// Shared definitions for the elevator request path and the elevator controller.
package elev_pkg;

    localparam int FLOORS       = 7;
    localparam int FLOOR_W      = 3;
    localparam int NF_W         = 4;
    localparam int NF_VALID_BIT = 3;

    // Floor 7 has no hall-up button and floor 1 has no hall-down button.
    localparam logic [FLOORS-1:0] UP_BTN_MASK = 7'b0111111;
    localparam logic [FLOORS-1:0] DN_BTN_MASK = 7'b1111110;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10
    } dir_e;

    // Result of scanning a floor mask: lowest and highest set floor (1-based).
    typedef struct packed {
        logic               any;
        logic [FLOOR_W-1:0] lo;
        logic [FLOOR_W-1:0] hi;
    } pick_t;

    // Floors strictly above cur.
    function automatic logic [FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] cur);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) begin
            m[i] = (i >= int'(cur));
        end
        return m;
    endfunction

    // Floors strictly below cur.
    function automatic logic [FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] cur);
        logic [FLOORS-1:0] m;
        for (int i = 0; i < FLOORS; i++) begin
            m[i] = ((i + 1) < int'(cur));
        end
        return m;
    endfunction

    // Valid target word for floor f.
    function automatic logic [NF_W-1:0] target(input logic [FLOOR_W-1:0] f);
        logic [NF_W-1:0] t;
        t                  = '0;
        t[NF_VALID_BIT]    = 1'b1;
        t[FLOOR_W-1:0]     = f;
        return t;
    endfunction

endpackage

// File: rtl/floor_pick.sv
// Finds the lowest and highest requested floor in a 7-bit floor mask.
module floor_pick
    import elev_pkg::*;
(
    input  logic [FLOORS-1:0] mask,
    output pick_t             pick
);

    // Lowest set floor wins the downward scan, highest wins the upward scan.
    always_comb begin
        pick = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (mask[i]) pick.lo = FLOOR_W'(i + 1);
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (mask[i]) pick.hi = FLOOR_W'(i + 1);
        end
        pick.any = |mask;
    end

endmodule

// File: rtl/call_registry.sv
// Call latches, lamps and SCAN target selection for the 7-floor elevator.
module call_registry #(
    parameter int FLOORS = elev_pkg::FLOORS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FLOORS-1:0]           cab_btn,
    input  logic [FLOORS-1:0]           hall_up,
    input  logic [FLOORS-1:0]           hall_dn,
    input  logic [elev_pkg::FLOOR_W-1:0] floor_cur,
    input  logic [1:0]                  dir_cur,
    input  logic                        arrived,
    output logic [elev_pkg::NF_W-1:0]   new_floor,
    output logic [FLOORS-1:0]           cab_lamp,
    output logic [FLOORS-1:0]           up_lamp,
    output logic [FLOORS-1:0]           dn_lamp,
    output logic [1:0]                  sweep
);

    import elev_pkg::*;

    logic [FLOORS-1:0] cab_prev_q, cab_prev_d;
    logic [FLOORS-1:0] up_prev_q,  up_prev_d;
    logic [FLOORS-1:0] dn_prev_q,  dn_prev_d;
    logic [FLOORS-1:0] cab_q, cab_d;
    logic [FLOORS-1:0] up_q,  up_d;
    logic [FLOORS-1:0] dn_q,  dn_d;
    dir_e              sweep_q, sweep_d;
    logic [NF_W-1:0]   new_floor_q, new_floor_d;

    logic              cur_ok;
    logic [FLOORS-1:0] cur_onehot;
    logic [FLOORS-1:0] cab_clr, up_clr, dn_clr;
    logic [FLOORS-1:0] above, below;
    logic [FLOORS-1:0] req_all;
    logic [FLOOR_W-1:0] dist_up, dist_dn;

    pick_t cu_above, dn_above, cd_below, up_below, r_above, r_below;

    // Each scan only needs one end of its mask; the other end is collected here.
    logic [17:0] pick_unused;
    assign pick_unused = {cu_above.hi, dn_above.lo, cd_below.lo,
                          up_below.hi, r_above.hi, r_below.lo};

    // Button edge detection, arrival clears, and next latch values.
    always_comb begin
        cab_prev_d = cab_btn;
        up_prev_d  = hall_up;
        dn_prev_d  = hall_dn;

        cur_ok     = (floor_cur != '0);
        cur_onehot = '0;
        if (cur_ok) cur_onehot = FLOORS'(1) << (floor_cur - FLOOR_W'(1));

        cab_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        if (arrived) begin
            cab_clr = cur_onehot;
            if ((dir_cur != DIR_DN) || (floor_cur == FLOOR_W'(1))) up_clr = cur_onehot;
            if ((dir_cur != DIR_UP) || (floor_cur == FLOOR_W'(7))) dn_clr = cur_onehot;
        end

        cab_d = (cab_q | (cab_btn & ~cab_prev_q)) & ~cab_clr;
        up_d  = (up_q  | (hall_up & ~up_prev_q))  & ~up_clr & UP_BTN_MASK;
        dn_d  = (dn_q  | (hall_dn & ~dn_prev_q))  & ~dn_clr & DN_BTN_MASK;
    end

    assign above   = above_mask(floor_cur);
    assign below   = below_mask(floor_cur);
    assign req_all = cab_q | up_q | dn_q;

    floor_pick u_cu_above (.mask((cab_q | up_q) & above), .pick(cu_above));
    floor_pick u_dn_above (.mask(dn_q & above),           .pick(dn_above));
    floor_pick u_cd_below (.mask((cab_q | dn_q) & below), .pick(cd_below));
    floor_pick u_up_below (.mask(up_q & below),           .pick(up_below));
    floor_pick u_r_above  (.mask(req_all & above),        .pick(r_above));
    floor_pick u_r_below  (.mask(req_all & below),        .pick(r_below));

    // SCAN policy: continue the current sweep, reverse, or settle to idle.
    always_comb begin
        sweep_d     = sweep_q;
        new_floor_d = new_floor_q;
        dist_up     = r_above.lo - floor_cur;
        dist_dn     = floor_cur - r_below.hi;
        if (cur_ok) begin
            case (sweep_q)
                DIR_UP: begin
                    if (cu_above.any)      new_floor_d = target(cu_above.lo);
                    else if (dn_above.any) new_floor_d = target(dn_above.hi);
                    else if (r_below.any)  sweep_d     = DIR_DN;
                    else                   sweep_d     = DIR_IDLE;
                end
                DIR_DN: begin
                    if (cd_below.any)      new_floor_d = target(cd_below.hi);
                    else if (up_below.any) new_floor_d = target(up_below.lo);
                    else if (r_above.any)  sweep_d     = DIR_UP;
                    else                   sweep_d     = DIR_IDLE;
                end
                default: begin
                    if ((req_all & cur_onehot) != '0) begin
                        new_floor_d = target(floor_cur);
                    end else if (r_above.any && (!r_below.any || (dist_up <= dist_dn))) begin
                        new_floor_d = target(r_above.lo);
                        sweep_d     = DIR_UP;
                    end else if (r_below.any) begin
                        new_floor_d = target(r_below.hi);
                        sweep_d     = DIR_DN;
                    end else begin
                        new_floor_d = '0;
                    end
                end
            endcase
        end
    end

    // Call latches and button edge registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cab_prev_q <= '0;
            up_prev_q  <= '0;
            dn_prev_q  <= '0;
            cab_q      <= '0;
            up_q       <= '0;
            dn_q       <= '0;
        end else begin
            cab_prev_q <= cab_prev_d;
            up_prev_q  <= up_prev_d;
            dn_prev_q  <= dn_prev_d;
            cab_q      <= cab_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
        end
    end

    // Sweep state and registered target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_q     <= DIR_IDLE;
            new_floor_q <= '0;
        end else begin
            sweep_q     <= sweep_d;
            new_floor_q <= new_floor_d;
        end
    end

    assign new_floor = new_floor_q;
    assign cab_lamp  = cab_q;
    assign up_lamp   = up_q;
    assign dn_lamp   = dn_q;
    assign sweep     = sweep_q;

endmodule

// File: doc/call_registry.md
# call_registry

Upstream request stage of the 7-floor, two-way elevator. Captures cab and hall button presses into persistent call latches and drives the lamps. Runs a SCAN (sweep) policy against the car's reported floor and direction. Presents one registered target floor to the elevator controller on `new_floor`.

## Interface

Parameters:
- `FLOORS`, 7: number of floors, numbered 1..FLOORS. The RTL is written for 7 and does not scale beyond 7.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `cab_btn`  input  7  cab buttons; bit i = floor i+1; level, may be held.
- `hall_up`  input  7  hall up buttons; bit 6 (floor 7) ignored.
- `hall_dn`  input  7  hall down buttons; bit 0 (floor 1) ignored.
- `floor_cur`  input  3  car floor from the elevator controller, 1..7; 0 is invalid and freezes selection.
- `dir_cur`  input  2  car direction: 00 idle, 01 up, 10 down, 11 illegal (treated as idle).
- `arrived`  input  1  one-cycle pulse when the car stops with door opening at `floor_cur`.
- `new_floor`  output  4  bit 3 = valid; bits 2:0 = target floor 1..7.
- `cab_lamp`  output  7  cab call latches.
- `up_lamp`  output  7  hall up latches; bit 6 is always 0.
- `dn_lamp`  output  7  hall down latches; bit 0 is always 0.
- `sweep`  output  2  internal sweep state, same encoding as `dir_cur`.

## Operation

Reset (asserted low):
- All latches 0.
- `new_floor` = 4'b0000.
- `sweep` = 00 (IDLE).
- Edge-detect registers 0.

Capture:
- Each button is rising-edge detected against a registered copy. A held button registers exactly once.
- A rising edge sets the matching latch.

Clear:
- On `arrived`, at floor f = `floor_cur`:
  - `cab_lamp[f-1]` clears always.
  - `up_lamp[f-1]` clears if `dir_cur` is 00 or 01, or f = 1.
  - `dn_lamp[f-1]` clears if `dir_cur` is 00 or 10, or f = 7.
- If a set and a clear of the same latch occur in the same cycle, the clear wins.

Sweep FSM and target selection. Let R = cab | up | dn (per floor).
- IDLE:
  - R at `floor_cur` → target = `floor_cur`, stay IDLE.
  - Otherwise the nearest R floor. On an equal-distance tie, the upper floor wins. Go UP or DOWN toward it.
  - No R → valid = 0.
- UP:
  - Target = lowest floor > cur with cab|up.
  - Else highest floor > cur with dn.
  - Else, if any R below cur → go DOWN and re-select in the next cycle; `new_floor` holds its previous value for that cycle.
  - Else → IDLE.
- DOWN: mirror of UP. Highest floor < cur with cab|dn; else lowest floor < cur with up; else UP if any R above; else IDLE.
- `floor_cur` = 0: FSM and `new_floor` hold their values.

Width rules: floor math is 3-bit unsigned. Comparisons are strict; the current floor is excluded in UP and DOWN.

## Timing

- Button rising edge in cycle n → lamp high at edge n+1 → `new_floor` updated at edge n+2.
- `arrived` in cycle n → latch cleared at edge n+1 → `new_floor` reflects it at edge n+2.
- `new_floor` is fully registered. It changes at most once per cycle and holds stable while inputs are static.
- Reset asserted mid-sweep → immediate return to the reset values, asynchronously. Release is synchronous to `clk`; the first capture is possible at the first edge after release.
- Button held through reset deassertion: the edge register comes out of reset at 0, so a held button latches at the first edge after release.

## Structure

- Shared package `elev_pkg`:
  - `FLOORS`
  - floor width (3)
  - direction codes DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DN=2'b10
  - `new_floor` valid-bit position (3)
  - The elevator controller imports the same package.
- Sub-module `floor_pick`: combinational. Takes a 7-bit mask and returns the lowest and highest set floor plus an any-set flag. call_registry instantiates it for each masked vector (above/below cur, cab|up, dn, R).

## Test plan

- Reset low with all buttons high → all lamps 0, `new_floor`=0; release reset → `cab_lamp`=7'h7F one cycle later.
- Idle at floor 1, pulse `cab_btn[4]` → `cab_lamp[4]`=1, then `new_floor`=4'b1101, `sweep`=01.
- Sweep UP at floor 2 with `hall_dn[5]` and `cab_btn[3]` set → `new_floor`=4'b1100 (floor 4); after `arrived` at 4 → 4'b1110 (floor 6).
- Sweep UP at floor 6, only `cab_lamp[1]` pending → `sweep`=10 next cycle, then `new_floor`=4'b1010.
- `arrived` at floor 3 with `dir_cur`=01 while `up_lamp[2]` and `dn_lamp[2]` are set → up clears, dn stays.
- `hall_up[2]` edge in the same cycle as `arrived` at floor 3 idle → latch stays 0; idle with no calls → `new_floor` valid bit 0.
